// File: rtl/mem_arbiter_pkg.sv
// Shared cpu package for the memory arbiter.
// Holds the requester-ID enum used for the pending read owner and the
// last-grant pointer, the default bus widths and a saturating counter helper.
package mem_arbiter_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 17;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int CNT_WIDTH          = 16;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IF   = 2'd1,
    REQ_LS   = 2'd2
  } req_id_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2: two-requester round-robin arbiter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req[1:0]    - requests, bit 0 = instruction fetch, bit 1 = load/store
//   gnt[1:0]    - one-hot (or zero) combinational grants, same bit order
// Owns the last-grant pointer. It resets to LS so that fetch wins the first
// conflict, and it moves only in cycles where a grant is actually issued.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Contention: favour whoever was not served most recently.
      2'b11:   gnt = (last_q == REQ_LS) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_LS;
    end else if (gnt[0]) begin
      last_q <= REQ_IF;
    end else if (gnt[1]) begin
      last_q <= REQ_LS;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between an instruction-fetch port
// and a load/store port.
// Ports:
//   clk, a_reset_n                 - clock, asynchronous active-low reset
//   if_req/if_addr                 - fetch read request (held until granted)
//   if_gnt/if_rvalid               - fetch accepted / fetch data valid
//   ls_req/ls_we/ls_addr/ls_wdata  - load/store request (held until granted)
//   ls_gnt/ls_rvalid               - load/store accepted / load data valid
//   rdata                          - shared read data, qualified by the rvalids
//   ram_address/ram_we/ram_re/ram_wdata - RAM command, driven in grant cycle
//   ram_rdata                      - RAM read data, one cycle after ram_re
//   conflict_cnt                   - saturating count of contention cycles
// Handshake: a request is accepted in the cycle its gnt is high (gnt is a
// combinational function of the requests and the last-grant pointer); a
// granted read returns data with a one-cycle rvalid pulse in the next cycle.
// Stores finish in their grant cycle and never pulse rvalid.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  a_reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [15:0]           conflict_cnt
);

  logic [1:0] req;
  logic [1:0] gnt;
  req_id_e    pend_q;
  req_id_e    pend_d;
  logic [15:0] cnt_q;

  // Masking with reset keeps grants low while reset is asserted.
  assign req = {ls_req & a_reset_n, if_req & a_reset_n};

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (a_reset_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign if_gnt = gnt[0];
  assign ls_gnt = gnt[1];

  // RAM command from the winner; idle cycles drive zeros on the don't-care
  // fields to keep the bus quiet.
  always_comb begin
    ram_address = '0;
    ram_wdata   = '0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    if (gnt[0]) begin
      ram_address = if_addr;
      ram_re      = 1'b1;
    end else if (gnt[1]) begin
      ram_address = ls_addr;
      ram_we      = ls_we;
      ram_re      = ~ls_we;
      ram_wdata   = ls_wdata;
    end
  end

  // Pending-owner register: records who gets the data returning next cycle.
  // It is rewritten every cycle, so back-to-back reads overlap cleanly.
  always_comb begin
    pend_d = REQ_NONE;
    if (gnt[0]) begin
      pend_d = REQ_IF;
    end else if (gnt[1] && !ls_we) begin
      pend_d = REQ_LS;
    end
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      pend_q <= REQ_NONE;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign if_rvalid = (pend_q == REQ_IF);
  assign ls_rvalid = (pend_q == REQ_LS);
  assign rdata     = ram_rdata;

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      cnt_q <= '0;
    end else if (if_req && ls_req) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign conflict_cnt = cnt_q;

endmodule
